// File: rtl/hazard_pkg.sv
// Shared types, constants and the forwarding-select helper for hazard_ctrl.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // Memory-stage result is newer than Writeback, so it wins; x0 is never forwarded.
  function automatic fwd_sel_t fwd_sel(input logic [4:0] rs,
                                       input logic [4:0] rd_m,
                                       input logic       reg_write_m,
                                       input logic [4:0] rd_w,
                                       input logic       reg_write_w);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard unit signal bundle.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import hazard_pkg::*;

  logic [4:0]       Rs1D, Rs2D;
  logic [4:0]       Rs1E, Rs2E;
  logic [4:0]       RdE, RdM, RdW;
  logic [1:0]       ResultSrcE;
  logic             RegWriteM, RegWriteW;
  logic             PCSrcE;
  logic             MemReqM, MemReadyM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM;
  logic             FlushD, FlushE;
  logic             MemErr;
  logic [CNT_W-1:0] StallCnt, FlushCnt;

  // Pipeline side: supplies hazard information, consumes controls.
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, MemErr, StallCnt, FlushCnt
  );

  // Hazard unit side.
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
           RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
    output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
           FlushD, FlushE, MemErr, StallCnt, FlushCnt
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: counts cycles with inc=1, holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // Increment on each qualifying cycle until all-ones, never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forwarding control for the 5-stage RV32I pipeline, with a
// data-memory wait FSM, sticky timeout flag and perf event counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  localparam int             TW    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0]  T_MAX = TW'(MEM_TIMEOUT);

  hz_state_t     r_state, w_next;
  logic [TW-1:0] r_timer;
  logic          r_mem_err;
  logic          w_req_miss, w_mem_hold, w_load_use;
  logic          w_stall_f, w_flush_e;

  assign w_req_miss = bus.MemReqM && !bus.MemReadyM;
  assign w_mem_hold = (r_state == MEM_WAIT) || w_req_miss;
  assign w_load_use = (bus.ResultSrcE == RESULT_SRC_LOAD) && (bus.RdE != 5'd0) &&
                      ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state: wait for memory until the first ready cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN:      if (w_req_miss)    w_next = MEM_WAIT;
      MEM_WAIT: if (bus.MemReadyM) w_next = RUN;
      default:                     w_next = RUN;
    endcase
  end

  // Wait timer (1 on the first wait cycle, holds at the limit) and sticky timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer   <= '0;
      r_mem_err <= 1'b0;
    end else begin
      if (w_next == RUN) begin
        r_timer <= '0;
      end else if (r_state == RUN) begin
        r_timer <= TW'(1);
      end else if (r_timer != T_MAX) begin
        r_timer <= r_timer + TW'(1);
      end
      if ((r_state == MEM_WAIT) && (r_timer == T_MAX)) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  // Outputs: memory hold > redirect > load-use bubble; all quiet in reset.
  always_comb begin
    bus.ForwardAE = FWD_RF;
    bus.ForwardBE = FWD_RF;
    bus.StallF    = 1'b0;
    bus.StallD    = 1'b0;
    bus.StallE    = 1'b0;
    bus.StallM    = 1'b0;
    bus.FlushD    = 1'b0;
    bus.FlushE    = 1'b0;
    if (!rst) begin
      bus.ForwardAE = fwd_sel(bus.Rs1E, bus.RdM, bus.RegWriteM, bus.RdW, bus.RegWriteW);
      bus.ForwardBE = fwd_sel(bus.Rs2E, bus.RdM, bus.RegWriteM, bus.RdW, bus.RegWriteW);
      if (w_mem_hold) begin
        bus.StallF = 1'b1;
        bus.StallD = 1'b1;
        bus.StallE = 1'b1;
        bus.StallM = 1'b1;
      end else if (bus.PCSrcE) begin
        bus.FlushD = 1'b1;
        bus.FlushE = 1'b1;
      end else if (w_load_use) begin
        bus.StallF = 1'b1;
        bus.StallD = 1'b1;
        bus.FlushE = 1'b1;
      end
    end
  end

  assign w_stall_f  = bus.StallF;
  assign w_flush_e  = bus.FlushE;
  assign bus.MemErr = r_mem_err;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall_f),
    .count (bus.StallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_flush_e),
    .count (bus.FlushCnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (small counters and short timeout).
module tb_hazard_ctrl;
  import hazard_pkg::*;

  localparam int CNT_W = 4;
  localparam int MEM_TIMEOUT = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.Rs1D = 5'd0; bus.Rs2D = 5'd0; bus.Rs1E = 5'd0; bus.Rs2E = 5'd0;
    bus.RdE = 5'd0; bus.RdM = 5'd0; bus.RdW = 5'd0; bus.ResultSrcE = 2'b00;
    bus.RegWriteM = 1'b0; bus.RegWriteW = 1'b0; bus.PCSrcE = 1'b0;
    bus.MemReqM = 1'b0; bus.MemReadyM = 1'b0;
  endtask

  function automatic logic [3:0] stalls();
    return {bus.StallF, bus.StallD, bus.StallE, bus.StallM};
  endfunction

  function automatic logic [1:0] flushes();
    return {bus.FlushD, bus.FlushE};
  endfunction

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    clear_inputs();
    #12;
    chk("rst_stalls", 32'(stalls()), 32'h0);
    chk("rst_flush", 32'(flushes()), 32'h0);
    chk("rst_memerr", 32'(bus.MemErr), 32'h0);
    chk("rst_stallcnt", 32'(bus.StallCnt), 32'h0);
    chk("rst_flushcnt", 32'(bus.FlushCnt), 32'h0);
    rst = 1'b0;

    // T1: Memory beats Writeback, then Writeback alone
    bus.RdM = 5'd5; bus.RegWriteM = 1'b1; bus.RdW = 5'd5; bus.RegWriteW = 1'b1;
    bus.Rs1E = 5'd5;
    #1 chk("t1_fwdA_mem", 32'(bus.ForwardAE), 32'h2);
    chk("t1_fwdB_rf", 32'(bus.ForwardBE), 32'h0);
    bus.RegWriteM = 1'b0;
    #1 chk("t1_fwdA_wb", 32'(bus.ForwardAE), 32'h1);
    bus.Rs2E = 5'd5;
    #1 chk("t1_fwdB_wb", 32'(bus.ForwardBE), 32'h1);

    // T2: x0 never forwarded
    clear_inputs();
    bus.RdM = 5'd0; bus.RegWriteM = 1'b1; bus.Rs2E = 5'd0;
    bus.RdW = 5'd0; bus.RegWriteW = 1'b1;
    #1 chk("t2_fwdB_x0", 32'(bus.ForwardBE), 32'h0);
    chk("t2_fwdA_x0", 32'(bus.ForwardAE), 32'h0);

    // T3: load-use bubble for one cycle
    tick();
    clear_inputs();
    bus.ResultSrcE = 2'b01; bus.RdE = 5'd7; bus.Rs2D = 5'd7;
    #1 chk("t3_stalls", 32'(stalls()), 32'hC);
    chk("t3_flush", 32'(flushes()), 32'h1);
    tick();
    clear_inputs();
    #1 chk("t3_stallcnt", 32'(bus.StallCnt), 32'h1);
    chk("t3_flushcnt", 32'(bus.FlushCnt), 32'h1);
    chk("t3_quiet", 32'({stalls(), flushes()}), 32'h0);

    // T4: redirect wins over load-use
    bus.ResultSrcE = 2'b01; bus.RdE = 5'd9; bus.Rs1D = 5'd9; bus.PCSrcE = 1'b1;
    #1 chk("t4_flush", 32'(flushes()), 32'h3);
    chk("t4_stalls", 32'(stalls()), 32'h0);
    tick();
    clear_inputs();
    #1 chk("t4_stallcnt", 32'(bus.StallCnt), 32'h1);
    chk("t4_flushcnt", 32'(bus.FlushCnt), 32'h2);

    // T5: three miss cycles then ready -> four held cycles; redirect held off
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b0; bus.PCSrcE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("t5_hold%0d_stalls", i), 32'(stalls()), 32'hF);
      chk($sformatf("t5_hold%0d_flush", i), 32'(flushes()), 32'h0);
      tick();
    end
    bus.MemReadyM = 1'b1;
    #1 chk("t5_ready_stalls", 32'(stalls()), 32'hF);
    chk("t5_ready_flush", 32'(flushes()), 32'h0);
    tick();
    clear_inputs();
    #1 chk("t5_run_stalls", 32'(stalls()), 32'h0);
    chk("t5_stallcnt", 32'(bus.StallCnt), 32'h5);
    chk("t5_flushcnt", 32'(bus.FlushCnt), 32'h2);
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b1;
    #1 chk("t5_hit_stalls", 32'(stalls()), 32'h0);
    tick();
    clear_inputs();
    #1 chk("t5_hit_next_stalls", 32'(stalls()), 32'h0);
    chk("t5_hit_stallcnt", 32'(bus.StallCnt), 32'h5);

    // T6: timeout after the 4th wait cycle, then async reset mid-wait
    bus.MemReqM = 1'b1; bus.MemReadyM = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("t6_memerr_edge%0d", i), 32'(bus.MemErr), 32'h0);
    end
    tick();
    chk("t6_memerr_set", 32'(bus.MemErr), 32'h1);
    chk("t6_still_wait", 32'(stalls()), 32'hF);
    tick();
    chk("t6_memerr_sticky", 32'(bus.MemErr), 32'h1);
    bus.RdM = 5'd5; bus.RegWriteM = 1'b1; bus.Rs1E = 5'd5;
    #2 rst = 1'b1;
    #1 chk("t6_rst_memerr", 32'(bus.MemErr), 32'h0);
    chk("t6_rst_stalls", 32'(stalls()), 32'h0);
    chk("t6_rst_fwdA", 32'(bus.ForwardAE), 32'h0);
    chk("t6_rst_stallcnt", 32'(bus.StallCnt), 32'h0);
    rst = 1'b0;
    clear_inputs();
    #1 chk("t6_run_stalls", 32'(stalls()), 32'h0);
    tick();
    chk("t6_run_next_stalls", 32'(stalls()), 32'h0);
    chk("t6_run_memerr", 32'(bus.MemErr), 32'h0);

    // Counter saturation: continuous load-use stalls
    bus.ResultSrcE = 2'b01; bus.RdE = 5'd3; bus.Rs1D = 5'd3;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_stall14", 32'(bus.StallCnt), 32'hE);
    chk("sat_flush14", 32'(bus.FlushCnt), 32'hE);
    tick();
    chk("sat_stall15", 32'(bus.StallCnt), 32'hF);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_stall_hold", 32'(bus.StallCnt), 32'hF);
    chk("sat_flush_hold", 32'(bus.FlushCnt), 32'hF);
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
